apb_reg_slave: RTL and testbench



---
 rtl/apb_reg_slave.sv | 118 +++++++++++
 tb/tb_apb_reg_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB3 completer with NUM_REGS 32-bit read/write registers.
// Each access phase takes WAIT_CYCLES+1 cycles. Reads and writes to an
// out-of-range or misaligned address get an error response.
// Register contents and one-cycle write strobes are exported to local logic.
module apb_reg_slave #(
    parameter int NUM_REGS       = 8,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int WAIT_CYCLES    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    input  logic                      pwrite,
    input  logic                      psel,
    input  logic                      penable,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic [NUM_REGS-1:0][31:0] reg_q,
    output logic [NUM_REGS-1:0]       reg_wr
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int IDX_W = (NUM_REGS < 2) ? 1 : $clog2(NUM_REGS);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             valid_reg;
    logic             write_reg;
    logic [31:0]      wdata_reg;

    logic [31:0]      idx_ext;
    logic             addr_valid;
    logic             commit;

    // Word index widened to 32 bits so the range test is a plain compare.
    assign idx_ext    = 32'(paddr[APB_ADDR_WIDTH-1:2]);
    assign addr_valid = (idx_ext < 32'(NUM_REGS)) && (paddr[1:0] == 2'b00);

    // The last access cycle is recognised from state and counter alone, so
    // pready does not depend on any bus input.
    assign pready  = (state_reg == ACCESS) && (cnt_reg == '0);
    assign commit  = pready && psel;
    assign pslverr = pready && !valid_reg;
    assign prdata  = (pready && valid_reg && !write_reg) ? reg_q[idx_reg] : 32'h0;

    // Transfer sequencing: capture in setup, count down wait states, then complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            write_reg <= 1'b0;
            wdata_reg <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // penable already high here is a protocol violation and is ignored.
                    if (psel && !penable) begin
                        // An invalid index is stored as 0 so the read mux never
                        // sees an out-of-range select.
                        idx_reg   <= addr_valid ? idx_ext[IDX_W-1:0] : '0;
                        valid_reg <= addr_valid;
                        write_reg <= pwrite;
                        wdata_reg <= pwdata;
                        cnt_reg   <= CNT_W'(WAIT_CYCLES);
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [31:0] q_reg;
            logic        wr_reg;
            logic        hit;

            assign hit = commit && valid_reg && write_reg && (idx_reg == IDX_W'(gi));

            // Register storage plus a strobe that is high the cycle after its update.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg  <= 32'h0;
                    wr_reg <= 1'b0;
                end else begin
                    wr_reg <= hit;
                    if (hit) begin
                        q_reg <= wdata_reg;
                    end
                end
            end

            assign reg_q[gi]  = q_reg;
            assign reg_wr[gi] = wr_reg;
        end
    endgenerate

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: three completers (WAIT_CYCLES 1, 0, 3) share one bus; the
// bench selects one per transfer and checks it against an array model.
module tb_apb_reg_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        penable;
    logic [2:0]  psel_v;

    logic [31:0]      prdata_v  [3];
    logic             pready_v  [3];
    logic             pslverr_v [3];
    logic [7:0][31:0] rq_v      [3];
    logic [7:0]       rw_v      [3];

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] model [3][8];
    int          waits [3] = '{1, 0, 3};

    always #5 clk = ~clk;

    apb_reg_slave #(.NUM_REGS(8), .APB_ADDR_WIDTH(12), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel_v[0]), .penable(penable), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]), .reg_q(rq_v[0]), .reg_wr(rw_v[0]));

    apb_reg_slave #(.NUM_REGS(8), .APB_ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel_v[1]), .penable(penable), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]), .reg_q(rq_v[1]), .reg_wr(rw_v[1]));

    apb_reg_slave #(.NUM_REGS(8), .APB_ADDR_WIDTH(12), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel_v[2]), .penable(penable), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2]), .reg_q(rq_v[2]), .reg_wr(rw_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++)
                model[d][i] = 32'h0;
    endtask

    task automatic check_regs(input int d);
        for (int i = 0; i < 8; i++)
            chk($sformatf("reg_q d%0d[%0d]", d, i), rq_v[d][i], model[d][i]);
    endtask

    // One APB transfer to DUT d. a2/wd2 are driven on the bus during the access
    // phase to show that only the setup-phase values matter. abort drops psel
    // in the first access cycle.
    task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                        input bit abort, input logic [11:0] a2, input logic [31:0] wd2);
        int          idx;
        bit          ok;
        int          lat;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        logic        got_err;
        idx    = int'(a) / 4;
        ok     = (a % 4 == 0) && (idx < 8);
        lat    = waits[d] + 1;
        exp_rd = 32'h0;
        got_rd = 32'h0;
        got_err = 1'b0;

        psel_v    = 3'b000;
        psel_v[d] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = a;
        pwdata    = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr   = a2;
        pwdata  = wd2;
        for (int dd = 0; dd < 3; dd++)
            chk($sformatf("reg_wr_quiet d%0d", dd), {24'h0, rw_v[dd]}, 32'h0);

        if (abort) begin
            psel_v  = 3'b000;
            penable = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                chk($sformatf("pready_abort d%0d", d), {31'h0, pready_v[d]}, 32'h0);
                chk($sformatf("reg_wr_abort d%0d", d), {24'h0, rw_v[d]}, 32'h0);
            end
            check_regs(d);
            $display("xfer d%0d %s addr=0x%03h data=0x%08h aborted", d, wr ? "WR" : "RD", a, wd);
            return;
        end

        for (int c = 1; c <= lat; c++) begin
            if (c < lat) begin
                chk($sformatf("pready_wait d%0d c%0d", d, c), {31'h0, pready_v[d]}, 32'h0);
                chk($sformatf("pslverr_wait d%0d", d), {31'h0, pslverr_v[d]}, 32'h0);
                chk($sformatf("prdata_wait d%0d", d), prdata_v[d], 32'h0);
                @(posedge clk); #1;
            end else begin
                if (ok && !wr) exp_rd = model[d][idx];
                got_rd  = prdata_v[d];
                got_err = pslverr_v[d];
                chk($sformatf("pready_done d%0d c%0d", d, c), {31'h0, pready_v[d]}, 32'h1);
                chk($sformatf("prdata d%0d", d), prdata_v[d], exp_rd);
                chk($sformatf("pslverr d%0d", d), {31'h0, pslverr_v[d]}, ok ? 32'h0 : 32'h1);
            end
        end

        @(posedge clk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        chk($sformatf("pready_one d%0d", d), {31'h0, pready_v[d]}, 32'h0);
        chk($sformatf("pslverr_after d%0d", d), {31'h0, pslverr_v[d]}, 32'h0);
        chk($sformatf("prdata_after d%0d", d), prdata_v[d], 32'h0);
        if (ok && wr) begin
            model[d][idx] = wd;
            chk($sformatf("reg_wr d%0d", d), {24'h0, rw_v[d]}, 32'h1 << idx);
        end else begin
            chk($sformatf("reg_wr d%0d", d), {24'h0, rw_v[d]}, 32'h0);
        end
        check_regs(d);
        $display("xfer d%0d %s addr=0x%03h wdata=0x%08h prdata=0x%08h pslverr=%0d",
                 d, wr ? "WR" : "RD", a, wd, got_rd, got_err);
    endtask

    initial begin
        rst     = 1'b1;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 12'h0;
        pwdata  = 32'h0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_prdata d%0d", d), prdata_v[d], 32'h0);
            chk($sformatf("rst_pready d%0d", d), {31'h0, pready_v[d]}, 32'h0);
            chk($sformatf("rst_pslverr d%0d", d), {31'h0, pslverr_v[d]}, 32'h0);
            chk($sformatf("rst_reg_wr d%0d", d), {24'h0, rw_v[d]}, 32'h0);
            check_regs(d);
        end
        rst = 1'b0;

        // Write then read back with one wait state.
        xfer(0, 1'b1, 12'h008, 32'hDEADBEEF, 1'b0, 12'h008, 32'hDEADBEEF);
        xfer(0, 1'b0, 12'h008, 32'h0, 1'b0, 12'h008, 32'h0);

        // Out-of-range read and misaligned write.
        xfer(0, 1'b0, 12'h020, 32'h0, 1'b0, 12'h020, 32'h0);
        xfer(0, 1'b1, 12'h005, 32'h11111111, 1'b0, 12'h005, 32'h11111111);

        // Zero and three wait states.
        xfer(1, 1'b1, 12'h00C, 32'hCAFEF00D, 1'b0, 12'h00C, 32'hCAFEF00D);
        xfer(1, 1'b0, 12'h00C, 32'h0, 1'b0, 12'h00C, 32'h0);
        xfer(2, 1'b1, 12'h01C, 32'h0BADF00D, 1'b0, 12'h01C, 32'h0BADF00D);
        xfer(2, 1'b0, 12'h01C, 32'h0, 1'b0, 12'h01C, 32'h0);

        // Aborted write, then normal traffic.
        xfer(0, 1'b1, 12'h004, 32'h12345678, 1'b1, 12'h004, 32'h12345678);
        xfer(0, 1'b1, 12'h004, 32'h55AA55AA, 1'b0, 12'h004, 32'h55AA55AA);
        xfer(0, 1'b0, 12'h004, 32'h0, 1'b0, 12'h004, 32'h0);
        xfer(2, 1'b1, 12'h000, 32'h77777777, 1'b1, 12'h000, 32'h77777777);

        // Reset during the access phase of a write to register 0.
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 12'h000;
        pwdata  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        penable = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        clear_model();
        chk("pready_after_rst", {31'h0, pready_v[0]}, 32'h0);
        chk("pslverr_after_rst", {31'h0, pslverr_v[0]}, 32'h0);
        chk("reg_wr_after_rst", {24'h0, rw_v[0]}, 32'h0);
        check_regs(0);
        $display("reset asserted during access phase of write 0x000");
        xfer(0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 32'h0);

        // Bus changes after setup are ignored.
        xfer(0, 1'b1, 12'h010, 32'h13579BDF, 1'b0, 12'h010, 32'h13579BDF);
        xfer(0, 1'b1, 12'h00C, 32'hA5A5A5A5, 1'b0, 12'h010, 32'h0);
        xfer(0, 1'b0, 12'h010, 32'h0, 1'b0, 12'h00C, 32'hFFFFFFFF);

        // Randomised back-to-back traffic over valid and invalid addresses.
        for (int n = 0; n < 80; n++) begin
            int          d;
            bit          wr;
            bit          ab;
            logic [11:0] a;
            logic [11:0] a2;
            logic [31:0] wd;
            logic [31:0] wd2;
            d   = int'($urandom_range(0, 2));
            wr  = 1'($urandom_range(0, 1));
            ab  = ($urandom_range(0, 9) == 0);
            a   = 12'($urandom_range(0, 47));
            a2  = 12'($urandom_range(0, 4095));
            wd  = $urandom;
            wd2 = $urandom;
            xfer(d, wr, a, wd, ab, a2, wd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
